// File: rtl/bs_shift_acc.sv
// Bit-serial shift-accumulator: weights MSB-first bit-plane partial sums from local_mac into one result.
// Optional macro BS_SHIFT_ACC_RELU_EN clamps negative results to zero at the result write.
module bs_shift_acc #(
  parameter int IN_BITS = 8,
  parameter int PSUM_W  = 15,
  parameter int ACC_W   = PSUM_W + IN_BITS + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_signed,
  input  logic              sus,
  input  logic              psum_valid,
  input  logic [PSUM_W-1:0] psum,
  output logic              busy,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(IN_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IN_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             in_signed_q;
  logic             sus_q;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] acc_result;

  assign state_dbg = state;

  // Handshake: psum_valid has no ready; in ACC every psum_valid=1 cycle consumes
  // exactly one bit-plane, and psum_valid is ignored in IDLE and DONE.
  always_comb begin
    p_ext = sus_q ? {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum}
                  : {{(ACC_W-PSUM_W){1'b0}}, psum};
    if (cnt == '0) begin
      // The MSB plane of a two's-complement activation carries negative weight.
      acc_next = in_signed_q ? -p_ext : p_ext;
    end else begin
      acc_next = (acc << 1) + p_ext;
    end
`ifdef BS_SHIFT_ACC_RELU_EN
    acc_result = acc_next[ACC_W-1] ? '0 : acc_next;
`else
    acc_result = acc_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      acc_out     <= '0;
      acc_valid   <= 1'b0;
      busy        <= 1'b0;
      in_signed_q <= 1'b0;
      sus_q       <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_ACC;
            acc         <= '0;
            cnt         <= '0;
            in_signed_q <= in_signed;
            sus_q       <= sus;
            busy        <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACC: begin
          if (psum_valid) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              // acc_out is only touched here, so it stays stable while busy.
              state     <= S_DONE;
              busy      <= 1'b0;
              acc_valid <= 1'b1;
              acc_out   <= acc_result;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
